muscle_twitch_scheduler: RTL and testbench

Time-multiplexed sequencer that evaluates the Fuglevand twitch difference equation for NUM_CH muscle channels on one shared floating-point arithmetic unit instead of one combinational mult/add chain per channel. On each simulation tick it walks every channel in order:
- fetches the spike count;
- issues the int-to-float, multiply, add and subtract operations over a valid/ready handshake;
- updates per-channel history;
- emits one active-force sample per channel.

It sits between the spike counters and the per-muscle total-force integrators.

---
 rtl/muscle_twitch_pkg.sv | 31 +++
 rtl/muscle_twitch_hist_ram.sv | 63 ++++++
 rtl/muscle_twitch_scheduler.sv | 157 +++++++++++++++
 tb/tb_muscle_twitch_scheduler.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muscle_twitch_pkg.sv
// muscle_twitch_pkg: shared encodings and constants for the muscle twitch scheduler
package muscle_twitch_pkg;

    typedef enum logic [1:0] {
        OP_I2F = 2'd0,
        OP_MUL = 2'd1,
        OP_ADD = 2'd2,
        OP_SUB = 2'd3
    } op_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_CONV,
        S_M_B1,
        S_M_A1,
        S_M_A2,
        S_ADD34,
        S_SUB,
        S_WRITE
    } state_e;

    localparam logic [1:0] CFG_B1   = 2'd0;
    localparam logic [1:0] CFG_A1   = 2'd1;
    localparam logic [1:0] CFG_A2   = 2'd2;
    localparam logic [1:0] CFG_RSVD = 2'd3;

    localparam logic [31:0] FP_ZERO     = 32'h0;
    localparam int          FP_SIGN_BIT = 31;

endpackage

// File: rtl/muscle_twitch_hist_ram.sv
// muscle_twitch_hist_ram: per-channel coefficient (b1, a1, a2) and history (x1, y1, y2) registers
module muscle_twitch_hist_ram
    import muscle_twitch_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cfg_we,
    input  logic [CH_W-1:0] cfg_ch,
    input  logic [1:0]      cfg_sel,
    input  logic [31:0]     cfg_data,
    input  logic            hist_we,
    input  logic [CH_W-1:0] ch,
    input  logic [31:0]     x_new,
    input  logic [31:0]     y_new,
    output logic [31:0]     b1,
    output logic [31:0]     a1,
    output logic [31:0]     a2,
    output logic [31:0]     x1,
    output logic [31:0]     y1,
    output logic [31:0]     y2
);

    logic [31:0] b1_m [NUM_CH];
    logic [31:0] a1_m [NUM_CH];
    logic [31:0] a2_m [NUM_CH];
    logic [31:0] x1_m [NUM_CH];
    logic [31:0] y1_m [NUM_CH];
    logic [31:0] y2_m [NUM_CH];

    assign b1 = b1_m[ch];
    assign a1 = a1_m[ch];
    assign a2 = a2_m[ch];
    assign x1 = x1_m[ch];
    assign y1 = y1_m[ch];
    assign y2 = y2_m[ch];

    // config writes land only while idle and history shifts only in WRITE, so the ports never collide
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                b1_m[i] <= FP_ZERO;
                a1_m[i] <= FP_ZERO;
                a2_m[i] <= FP_ZERO;
                x1_m[i] <= FP_ZERO;
                y1_m[i] <= FP_ZERO;
                y2_m[i] <= FP_ZERO;
            end
        end else begin
            if (cfg_we && cfg_sel == CFG_B1) b1_m[cfg_ch] <= cfg_data;
            if (cfg_we && cfg_sel == CFG_A1) a1_m[cfg_ch] <= cfg_data;
            if (cfg_we && cfg_sel == CFG_A2) a2_m[cfg_ch] <= cfg_data;
            if (hist_we) begin
                x1_m[ch] <= x_new;
                y1_m[ch] <= y_new;
                y2_m[ch] <= y1_m[ch];
            end
        end
    end

endmodule

// File: rtl/muscle_twitch_scheduler.sv
// muscle_twitch_scheduler: sweeps all channels through y = b1*x1 - (a1*y1 + a2*y2) on one shared FP unit; MUSCLE_TWITCH_CLAMP_EN clamps negative y to zero
module muscle_twitch_scheduler
    import muscle_twitch_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tick,
    output logic            busy,
    output logic            overrun,
    input  logic            cfg_we,
    input  logic [CH_W-1:0] cfg_ch,
    input  logic [1:0]      cfg_sel,
    input  logic [31:0]     cfg_data,
    output logic            cfg_err,
    output logic [CH_W-1:0] spike_ch,
    input  logic [31:0]     spike_cnt,
    output logic            op_valid,
    input  logic            op_ready,
    output logic [1:0]      op_code,
    output logic [31:0]     op_a,
    output logic [31:0]     op_b,
    input  logic            res_valid,
    input  logic [31:0]     res_data,
    output logic            force_valid,
    output logic [CH_W-1:0] force_ch,
    output logic [31:0]     force_data
);

    state_e          state, state_nx;
    logic [CH_W-1:0] ch, ch_nx;
    logic            fetch_ph, fetch_ph_nx, waiting, waiting_nx, is_op, res_take, last_ch;
    op_e             code;
    logic [31:0]     cnt, xf, t1, t3, t4, s, y, y_w;
    logic [31:0]     b1, a1, a2, x1, y1, y2;

    assign busy        = state != S_IDLE;
    assign is_op       = state inside {S_CONV, S_M_B1, S_M_A1, S_M_A2, S_ADD34, S_SUB};
    assign res_take    = is_op && waiting && res_valid;
    assign last_ch     = ch == CH_W'(NUM_CH - 1);
    assign spike_ch    = state == S_FETCH ? ch : '0;
    assign force_valid = state == S_WRITE;
    assign force_ch    = force_valid ? ch : '0;
    assign force_data  = force_valid ? y_w : FP_ZERO;
    assign op_code     = code;

`ifdef MUSCLE_TWITCH_CLAMP_EN
    assign y_w = y[FP_SIGN_BIT] ? FP_ZERO : y;
`else
    assign y_w = y;
`endif

    muscle_twitch_hist_ram #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_ram (
        .clk      (clk),
        .reset    (reset),
        .cfg_we   (cfg_we && !busy && cfg_sel != CFG_RSVD),
        .cfg_ch   (cfg_ch),
        .cfg_sel  (cfg_sel),
        .cfg_data (cfg_data),
        .hist_we  (force_valid),
        .ch       (ch),
        .x_new    (xf),
        .y_new    (y_w),
        .b1       (b1),
        .a1       (a1),
        .a2       (a2),
        .x1       (x1),
        .y1       (y1),
        .y2       (y2)
    );

    // sequencer state plus the sticky error flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            ch       <= '0;
            fetch_ph <= 1'b0;
            waiting  <= 1'b0;
            overrun  <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            state    <= state_nx;
            ch       <= ch_nx;
            fetch_ph <= fetch_ph_nx;
            waiting  <= waiting_nx;
            overrun  <= overrun | (tick & busy);
            cfg_err  <= cfg_err | (cfg_we & busy & (cfg_sel != CFG_RSVD));
        end
    end

    // next state and operand selection; operands depend only on state and registers, so they hold while issuing
    always_comb begin
        state_nx    = state;
        ch_nx       = ch;
        fetch_ph_nx = fetch_ph;
        waiting_nx  = waiting;
        op_valid    = 1'b0;
        code        = OP_I2F;
        op_a        = FP_ZERO;
        op_b        = FP_ZERO;
        case (state)
            S_IDLE: begin
                state_nx    = tick ? S_FETCH : S_IDLE;
                ch_nx       = '0;
                fetch_ph_nx = 1'b0;
            end
            S_FETCH: begin
                fetch_ph_nx = !fetch_ph;
                state_nx    = fetch_ph ? S_CONV : S_FETCH;
            end
            S_CONV:  op_a = cnt;
            S_M_B1:  begin code = OP_MUL; op_a = b1; op_b = x1; end
            S_M_A1:  begin code = OP_MUL; op_a = a1; op_b = y1; end
            S_M_A2:  begin code = OP_MUL; op_a = a2; op_b = y2; end
            S_ADD34: begin code = OP_ADD; op_a = t3; op_b = t4; end
            S_SUB:   begin code = OP_SUB; op_a = t1; op_b = s; end
            S_WRITE: begin
                state_nx = last_ch ? S_IDLE : S_FETCH;
                ch_nx    = last_ch ? '0 : ch + CH_W'(1);
            end
            default: state_nx = S_IDLE;
        endcase
        if (is_op) begin
            op_valid   = !waiting;
            waiting_nx = waiting ? !res_valid : op_ready;
            state_nx   = res_take ? state_e'(state + 4'd1) : state;
        end
    end

    // spike capture and op result registers; a result outside an op wait is dropped
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= FP_ZERO;
            xf  <= FP_ZERO;
            t1  <= FP_ZERO;
            t3  <= FP_ZERO;
            t4  <= FP_ZERO;
            s   <= FP_ZERO;
            y   <= FP_ZERO;
        end else begin
            if (state == S_FETCH && fetch_ph) cnt <= spike_cnt;
            if (res_take) begin
                case (state)
                    S_CONV:  xf <= res_data;
                    S_M_B1:  t1 <= res_data;
                    S_M_A1:  t3 <= res_data;
                    S_M_A2:  t4 <= res_data;
                    S_ADD34: s  <= res_data;
                    default: y  <= res_data;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muscle_twitch_scheduler.sv
// tb_muscle_twitch_scheduler: directed vectors against a latency-3 FP unit model with random op_ready back-pressure
module tb_muscle_twitch_scheduler;

    localparam int NUM_CH = 8;
    localparam int CH_W   = 3;
    localparam int L      = 3;
`ifdef MUSCLE_TWITCH_CLAMP_EN
    localparam logic [31:0] NEG = 32'h0;
`else
    localparam logic [31:0] NEG = 32'hBF800000;
`endif

    logic            clk, reset, tick, busy, overrun, cfg_we, cfg_err;
    logic [CH_W-1:0] cfg_ch, spike_ch, force_ch;
    logic [1:0]      cfg_sel, op_code;
    logic [31:0]     cfg_data, spike_cnt, op_a, op_b, res_data, force_data;
    logic            op_valid, op_ready, res_valid, force_valid;

    muscle_twitch_scheduler #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
        .clk(clk), .reset(reset), .tick(tick), .busy(busy), .overrun(overrun),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data), .cfg_err(cfg_err),
        .spike_ch(spike_ch), .spike_cnt(spike_cnt),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_data(res_data),
        .force_valid(force_valid), .force_ch(force_ch), .force_data(force_data)
    );

    typedef struct {
        logic [31:0] s0, s1, s2;
        logic [31:0] f0, f1, f2;
    } vec_t;

    int          n, errs, pulses, cyc, last_cyc, ready_mode;
    logic [CH_W-1:0] exp_ch;
    logic [31:0] fv [NUM_CH];
    logic [31:0] spikes [NUM_CH];
    logic        pv [4];
    logic [31:0] pd [4];
    vec_t        vecs [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic real s2r(input logic [31:0] b);
        real m;
        int  e;
        if (b[30:0] == 31'h0) return 0.0;
        e = int'(b[30:23]) - 127;
        m = 1.0 + real'(b[22:0]) / 8388608.0;
        for (int k = 0; k < e; k++) m = m * 2.0;
        for (int k = 0; k > e; k--) m = m / 2.0;
        return b[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2s(input real r);
        real a;
        int  e;
        if (r == 0.0) return 32'h0;
        a = r < 0.0 ? -r : r;
        e = 0;
        while (a >= 2.0 && e < 200) begin a = a / 2.0; e++; end
        while (a < 1.0 && e > -200) begin a = a * 2.0; e--; end
        return {r < 0.0, 8'(e + 127), 23'(longint'((a - 1.0) * 8388608.0))};
    endfunction

    function automatic logic [31:0] fp_op(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            2'd0:    return r2s(real'(a));
            2'd1:    return r2s(s2r(a) * s2r(b));
            2'd2:    return r2s(s2r(a) + s2r(b));
            default: return r2s(s2r(a) - s2r(b));
        endcase
    endfunction

    // FP unit and spike counter models: ready is chosen first, then an accept is queued for L cycles
    always @(negedge clk) begin
        op_ready = ready_mode == 1 ? 1'b1 : ready_mode == 2 ? 1'b0 : 1'($urandom_range(0, 1));
        for (int i = 3; i > 0; i--) begin
            pv[i] = pv[i-1];
            pd[i] = pd[i-1];
        end
        pv[0]     = op_valid && op_ready;
        pd[0]     = (op_valid && op_ready) ? fp_op(op_code, op_a, op_b) : 32'h0;
        res_valid = pv[3];
        res_data  = pd[3];
        spike_cnt = spikes[spike_ch];
    end

    // force collector with channel-order check
    always @(negedge clk) begin
        if (force_valid) begin
            chk("force_order", 32'(force_ch), 32'(exp_ch));
            fv[force_ch] = force_data;
            pulses++;
            exp_ch++;
            if (force_ch == CH_W'(NUM_CH - 1)) last_cyc = cyc;
        end
    end

    task automatic cfg(input int c, input int sel, input logic [31:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_ch = CH_W'(c); cfg_sel = 2'(sel); cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // mode 0 random ready, 1 ready tied high with latency checks, 2 stall first op, 3 tick/cfg during sweep
    task automatic sweep(input int mode);
        logic [31:0] ha, hb;
        logic [1:0]  hc;
        int          t0, i;
        for (int c = 0; c < NUM_CH; c++) fv[c] = 32'hDEADBEEF;
        pulses = 0;
        exp_ch = '0;
        ready_mode = mode == 1 ? 1 : mode == 2 ? 2 : 0;
        @(negedge clk);
        tick = 1'b1;
        t0 = cyc;
        @(negedge clk);
        tick = 1'b0;
        chk("busy_after_tick", 32'(busy), 32'd1);
        if (mode == 2) begin
            for (i = 0; i < 20 && !op_valid; i++) @(negedge clk);
            chk("hold_reach", 32'(op_valid), 32'd1);
            ha = op_a; hb = op_b; hc = op_code;
            repeat (5) begin
                @(negedge clk);
                chk("hold_valid", 32'(op_valid), 32'd1);
                chk("hold_a", op_a, ha);
                chk("hold_b", op_b, hb);
                chk("hold_code", 32'(op_code), 32'(hc));
            end
            ready_mode = 0;
        end
        for (i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (mode == 3 && i == 20) begin
                tick = 1'b1; cfg_we = 1'b1; cfg_ch = '0; cfg_sel = 2'd0; cfg_data = 32'h40000000;
            end else begin
                tick = 1'b0; cfg_we = 1'b0;
            end
            if (!busy) break;
        end
        chk("sweep_done", 32'(busy), 32'd0);
        chk("pulses", pulses, NUM_CH);
        if (mode == 1) begin
            chk("last_force_lat", last_cyc - t0, NUM_CH * (9 + 6 * L));
            chk("busy_fall_lat", cyc - t0, NUM_CH * (9 + 6 * L) + 1);
        end
    endtask

    initial begin
        int seen, acc;
        n = 0; errs = 0; cyc = 0; pulses = 0; last_cyc = 0; ready_mode = 0; exp_ch = '0;
        reset = 1'b0; tick = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_sel = 2'd0; cfg_data = 32'h0;
        op_ready = 1'b0; res_valid = 1'b0; res_data = 32'h0; spike_cnt = 32'h0;
        for (int i = 0; i < 4; i++) begin pv[i] = 1'b0; pd[i] = 32'h0; end
        for (int c = 0; c < NUM_CH; c++) begin spikes[c] = 32'h0; fv[c] = 32'h0; end

        vecs[0] = '{32'd3, 32'd2, 32'd1, 32'h00000000, 32'h00000000, 32'h00000000};
        vecs[1] = '{32'd0, 32'd0, 32'd1, 32'h40400000, 32'h40000000, NEG};
        vecs[2] = '{32'd0, 32'd0, 32'd1, 32'h00000000, 32'h3F800000, NEG};
        vecs[3] = '{32'd0, 32'd0, 32'd1, 32'h00000000, 32'h3F000000, NEG};

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        chk("rst_op_valid", 32'(op_valid), 32'd0);
        chk("rst_force_valid", 32'(force_valid), 32'd0);
        chk("rst_spike_ch", 32'(spike_ch), 32'd0);
        chk("rst_force_ch", 32'(force_ch), 32'd0);
        chk("rst_op_code", 32'(op_code), 32'd0);
        chk("rst_op_a", op_a, 32'h0);
        chk("rst_op_b", op_b, 32'h0);
        chk("rst_force_data", force_data, 32'h0);
        reset = 1'b1;

        cfg(0, 0, 32'h3F800000);
        cfg(1, 0, 32'h3F800000);
        cfg(1, 1, 32'hBF000000);
        cfg(2, 0, 32'hBF800000);
        chk("cfg_err_idle", 32'(cfg_err), 32'd0);

        for (int k = 0; k < 4; k++) begin
            spikes[0] = vecs[k].s0;
            spikes[1] = vecs[k].s1;
            spikes[2] = vecs[k].s2;
            sweep(k == 0 ? 1 : 0);
            chk($sformatf("tick%0d_ch0", k + 1), fv[0], vecs[k].f0);
            chk($sformatf("tick%0d_ch1", k + 1), fv[1], vecs[k].f1);
            chk($sformatf("tick%0d_ch2", k + 1), fv[2], vecs[k].f2);
            for (int c = 3; c < NUM_CH; c++) chk($sformatf("tick%0d_ch%0d", k + 1, c), fv[c], 32'h0);
        end

        spikes[0] = 32'd4; spikes[1] = 32'd0; spikes[2] = 32'd0;
        sweep(3);
        chk("overrun_set", 32'(overrun), 32'd1);
        chk("cfg_err_set", 32'(cfg_err), 32'd1);
        spikes[0] = 32'd0;
        sweep(0);
        chk("coef_unchanged", fv[0], 32'h40800000);
        chk("overrun_sticky", 32'(overrun), 32'd1);
        chk("cfg_err_sticky", 32'(cfg_err), 32'd1);

        for (int c = 0; c < NUM_CH; c++) spikes[c] = 32'd7;
        ready_mode = 1;
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        seen = 0; acc = 0;
        for (int i = 0; i < 2000 && acc < 3; i++) begin
            @(negedge clk);
            if (spike_ch == CH_W'(3)) seen = 1;
            if (seen != 0 && op_valid && op_ready) acc++;
        end
        chk("reach_ma1", acc, 3);
        chk("ma1_code", 32'(op_code), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_op_valid", 32'(op_valid), 32'd0);
        chk("midrst_force_valid", 32'(force_valid), 32'd0);
        chk("midrst_overrun", 32'(overrun), 32'd0);
        chk("midrst_cfg_err", 32'(cfg_err), 32'd0);
        chk("midrst_op_a", op_a, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("late_res_busy", 32'(busy), 32'd0);
        chk("late_res_op_valid", 32'(op_valid), 32'd0);

        sweep(0);
        for (int c = 0; c < NUM_CH; c++) chk($sformatf("postrst1_ch%0d", c), fv[c], 32'h0);
        sweep(2);
        for (int c = 0; c < NUM_CH; c++) chk($sformatf("postrst2_ch%0d", c), fv[c], 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n, errs);
        $finish;
    end

endmodule
